// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: registers ALU result and control, owns the Z/V/N
// flag register, resolves conditional branches and latches a sticky halt.
module ex_mem_stage #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [2:0]        cond,
  input  logic [DATA_W-1:0] alu_dst,
  input  logic              alu_ov,
  input  logic              alu_zr,
  input  logic              alu_neg,
  input  logic              change_v,
  input  logic              change_z,
  input  logic              change_n,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] pc_plus1,
  input  logic [DATA_W-1:0] branch_target,
  input  logic [3:0]        wr_reg,
  input  logic              mem_stall,
  output logic              out_valid,
  output logic [3:0]        out_op,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_store_data,
  output logic [3:0]        out_wr_reg,
  output logic              out_wr_en,
  output logic              out_mem_rd,
  output logic              out_mem_wr,
  output logic              flag_z,
  output logic              flag_v,
  output logic              flag_n,
  output logic              redirect,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              halt
);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_SRA = 4'h7;
  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_JAL = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  function automatic logic branch_taken(input logic [2:0] c, input logic z,
                                        input logic v, input logic n);
    logic t;
    case (c)
      3'b000:  t = !z;
      3'b001:  t = z;
      3'b010:  t = !z && !n;
      3'b011:  t = n;
      3'b100:  t = z || (!z && !n);
      3'b101:  t = n || z;
      3'b110:  t = v;
      default: t = 1'b1;
    endcase
    return t;
  endfunction

  function automatic logic writes_reg(input logic [3:0] o);
    return (o <= OP_LW) || (o == 4'hA) || (o == 4'hB) || (o == OP_JAL);
  endfunction

  logic              vld_p1;
  logic [3:0]        op_p1;
  logic [DATA_W-1:0] result_p1;
  logic [DATA_W-1:0] store_data_p1;
  logic [3:0]        wr_reg_p1;
  logic              wr_en_p1;
  logic              mem_rd_p1;
  logic              mem_wr_p1;
  logic              taken_p1;
  logic [DATA_W-1:0] redirect_pc_p1;
  logic              flag_z_p1;
  logic              flag_v_p1;
  logic              flag_n_p1;
  logic              halt_p1;

  logic acc;
  logic normal;
  logic z_op;
  logic vn_op;

  assign in_ready = !mem_stall && !halt_p1;
  assign acc      = in_valid && in_ready;
  assign redirect = vld_p1 && taken_p1;
  // The instruction accepted while a redirect is pending is the wrong path.
  assign normal   = acc && !redirect;
  assign z_op     = (op == OP_ADD) || ((op >= OP_SUB) && (op <= OP_SRA));
  assign vn_op    = (op == OP_ADD) || (op == OP_SUB);

  // ---- EX -> MEM boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1         <= 1'b0;
      op_p1          <= '0;
      result_p1      <= '0;
      store_data_p1  <= '0;
      wr_reg_p1      <= '0;
      wr_en_p1       <= 1'b0;
      mem_rd_p1      <= 1'b0;
      mem_wr_p1      <= 1'b0;
      taken_p1       <= 1'b0;
      redirect_pc_p1 <= '0;
      flag_z_p1      <= 1'b0;
      flag_v_p1      <= 1'b0;
      flag_n_p1      <= 1'b0;
      halt_p1        <= 1'b0;
    end else if (!mem_stall) begin
      if (normal) begin
        vld_p1        <= 1'b1;
        op_p1         <= op;
        result_p1     <= (op == OP_JAL) ? pc_plus1 : alu_dst;
        store_data_p1 <= store_data;
        wr_reg_p1     <= wr_reg;
        wr_en_p1      <= writes_reg(op) && (wr_reg != 4'h0);
        mem_rd_p1     <= (op == OP_LW);
        mem_wr_p1     <= (op == OP_SW);
        taken_p1      <= (op == OP_B) && branch_taken(cond, flag_z_p1, flag_v_p1, flag_n_p1);
        if (op == OP_B)
          redirect_pc_p1 <= branch_target;
        if (change_z && z_op)
          flag_z_p1 <= alu_zr;
        if (change_v && vn_op)
          flag_v_p1 <= alu_ov;
        if (change_n && vn_op)
          flag_n_p1 <= alu_neg;
        if (op == OP_HLT)
          halt_p1 <= 1'b1;
      end else begin
        // Bubble or squashed slot: kill the valid and all side-effect strobes.
        vld_p1    <= 1'b0;
        taken_p1  <= 1'b0;
        wr_en_p1  <= 1'b0;
        mem_rd_p1 <= 1'b0;
        mem_wr_p1 <= 1'b0;
      end
    end
  end

  assign out_valid      = vld_p1;
  assign out_op         = op_p1;
  assign out_result     = result_p1;
  assign out_store_data = store_data_p1;
  assign out_wr_reg     = wr_reg_p1;
  assign out_wr_en      = wr_en_p1;
  assign out_mem_rd     = mem_rd_p1;
  assign out_mem_wr     = mem_wr_p1;
  assign flag_z         = flag_z_p1;
  assign flag_v         = flag_v_p1;
  assign flag_n         = flag_n_p1;
  assign redirect_pc    = redirect_pc_p1;
  assign halt           = halt_p1;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: a sequential vector table plus hand-written
// stall, redirect-hold, async-reset and halt sequences.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [2:0]  cond;
  logic [15:0] alu_dst;
  logic        alu_ov, alu_zr, alu_neg;
  logic        change_v, change_z, change_n;
  logic [15:0] store_data, pc_plus1, branch_target;
  logic [3:0]  wr_reg;
  logic        mem_stall;
  logic        out_valid;
  logic [3:0]  out_op;
  logic [15:0] out_result, out_store_data;
  logic [3:0]  out_wr_reg;
  logic        out_wr_en, out_mem_rd, out_mem_wr;
  logic        flag_z, flag_v, flag_n;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;

  int ntests = 0;
  int nfail  = 0;

  ex_mem_stage #(.DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .cond(cond), .alu_dst(alu_dst),
    .alu_ov(alu_ov), .alu_zr(alu_zr), .alu_neg(alu_neg),
    .change_v(change_v), .change_z(change_z), .change_n(change_n),
    .store_data(store_data), .pc_plus1(pc_plus1), .branch_target(branch_target),
    .wr_reg(wr_reg), .mem_stall(mem_stall),
    .out_valid(out_valid), .out_op(out_op), .out_result(out_result),
    .out_store_data(out_store_data), .out_wr_reg(out_wr_reg), .out_wr_en(out_wr_en),
    .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
    .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [3:0]  op;
    logic [2:0]  cond;
    logic [15:0] dst;
    logic        ov, zr, ng, cv, cz, cn;
    logic [15:0] sd, pc1, bt;
    logic [3:0]  wr;
    logic        e_vld;
    logic [15:0] e_res;
    logic        e_we, e_rd, e_wr;
    logic        e_z, e_v, e_n;
    logic        e_rdr;
    logic [15:0] e_rpc;
  } vec_t;

  localparam int NV = 21;
  vec_t vt [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic iv, input logic [3:0] o, input logic [2:0] c,
                        input logic [15:0] d, input logic ov, input logic zr,
                        input logic ng, input logic cv, input logic cz, input logic cn,
                        input logic [15:0] sd, input logic [15:0] pc1,
                        input logic [15:0] bt, input logic [3:0] wr);
    in_valid = iv; op = o; cond = c; alu_dst = d;
    alu_ov = ov; alu_zr = zr; alu_neg = ng;
    change_v = cv; change_z = cz; change_n = cn;
    store_data = sd; pc_plus1 = pc1; branch_target = bt; wr_reg = wr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " valid"},  32'(out_valid), 0);
    chk({tag, " result"}, 32'(out_result), 0);
    chk({tag, " we"},     32'(out_wr_en), 0);
    chk({tag, " rd"},     32'(out_mem_rd), 0);
    chk({tag, " flags"},  32'({flag_z, flag_v, flag_n}), 0);
    chk({tag, " redir"},  32'(redirect), 0);
    chk({tag, " rpc"},    32'(redirect_pc), 0);
    chk({tag, " halt"},   32'(halt), 0);
  endtask

  initial begin
    //        iv op    cd dst      ov zr ng cv cz cn sd       pc1      bt       wr | vld res      we rd wr z  v  n  rdr rpc
    vt[0]  = '{1, 4'h2, 0, 16'h0005, 0, 1, 0, 1, 1, 1, 16'h0000, 16'h0000, 16'h0000, 4'h1, 1, 16'h0005, 1, 0, 0, 1, 0, 0, 0, 16'h0000};
    vt[1]  = '{1, 4'h3, 0, 16'h00F0, 1, 1, 1, 1, 1, 1, 16'h0000, 16'h0000, 16'h0000, 4'h2, 1, 16'h00F0, 1, 0, 0, 1, 0, 0, 0, 16'h0000};
    vt[2]  = '{1, 4'hC, 1, 16'h1111, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0040, 4'h0, 1, 16'h1111, 0, 0, 0, 1, 0, 0, 1, 16'h0040};
    vt[3]  = '{1, 4'h0, 0, 16'h2222, 1, 0, 1, 1, 1, 1, 16'h0000, 16'h0000, 16'h0000, 4'h3, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 0, 16'h0000};
    vt[4]  = '{1, 4'hC, 0, 16'h3333, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0080, 4'h0, 1, 16'h3333, 0, 0, 0, 1, 0, 0, 0, 16'h0000};
    vt[5]  = '{1, 4'h0, 0, 16'h0007, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 4'h0, 1, 16'h0007, 0, 0, 0, 1, 0, 0, 0, 16'h0000};
    vt[6]  = '{1, 4'h2, 0, 16'h8000, 1, 0, 1, 1, 1, 1, 16'h0000, 16'h0000, 16'h0000, 4'h4, 1, 16'h8000, 1, 0, 0, 0, 1, 1, 0, 16'h0000};
    vt[7]  = '{1, 4'hC, 3, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0100, 4'h0, 1, 16'h0000, 0, 0, 0, 0, 1, 1, 1, 16'h0100};
    vt[8]  = '{0, 4'h0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 4'h0, 0, 16'h0000, 0, 0, 0, 0, 1, 1, 0, 16'h0000};
    vt[9]  = '{1, 4'hC, 6, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0200, 4'h0, 1, 16'h0000, 0, 0, 0, 0, 1, 1, 1, 16'h0200};
    vt[10] = '{1, 4'hC, 2, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0500, 4'h0, 0, 16'h0000, 0, 0, 0, 0, 1, 1, 0, 16'h0000};
    vt[11] = '{1, 4'hC, 2, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0600, 4'h0, 1, 16'h0000, 0, 0, 0, 0, 1, 1, 0, 16'h0000};
    vt[12] = '{1, 4'hC, 5, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0300, 4'h0, 1, 16'h0000, 0, 0, 0, 0, 1, 1, 1, 16'h0300};
    vt[13] = '{1, 4'h9, 0, 16'h0030, 0, 0, 0, 0, 0, 0, 16'h1234, 16'h0000, 16'h0000, 4'h5, 0, 16'h0000, 0, 0, 0, 0, 1, 1, 0, 16'h0000};
    vt[14] = '{1, 4'h9, 0, 16'h0020, 0, 1, 0, 1, 1, 1, 16'hBEEF, 16'h0000, 16'h0000, 4'h5, 1, 16'h0020, 0, 0, 1, 0, 1, 1, 0, 16'h0000};
    vt[15] = '{1, 4'hC, 4, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0700, 4'h0, 1, 16'h0000, 0, 0, 0, 0, 1, 1, 0, 16'h0000};
    vt[16] = '{1, 4'hC, 7, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0400, 4'h0, 1, 16'h0000, 0, 0, 0, 0, 1, 1, 1, 16'h0400};
    vt[17] = '{0, 4'h0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 4'h0, 0, 16'h0000, 0, 0, 0, 0, 1, 1, 0, 16'h0000};
    vt[18] = '{1, 4'hA, 0, 16'hAB00, 0, 1, 0, 1, 1, 1, 16'h0000, 16'h0000, 16'h0000, 4'h6, 1, 16'hAB00, 1, 0, 0, 0, 1, 1, 0, 16'h0000};
    vt[19] = '{1, 4'hD, 0, 16'h9999, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0011, 16'h0000, 4'hF, 1, 16'h0011, 1, 0, 0, 0, 1, 1, 0, 16'h0000};
    vt[20] = '{1, 4'h8, 0, 16'h0044, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 4'h0, 1, 16'h0044, 0, 1, 0, 0, 1, 1, 0, 16'h0000};

    rst_n = 1'b0;
    mem_stall = 1'b0;
    set_in(0, 4'h0, 3'd0, 16'h0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 4'h0);
    step(); step();
    chk_all_zero("reset");
    chk("reset in_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Vector table: each record is one accept cycle, checked just after the edge.
    for (int i = 0; i < NV; i++) begin
      set_in(vt[i].iv, vt[i].op, vt[i].cond, vt[i].dst, vt[i].ov, vt[i].zr, vt[i].ng,
             vt[i].cv, vt[i].cz, vt[i].cn, vt[i].sd, vt[i].pc1, vt[i].bt, vt[i].wr);
      step();
      chk($sformatf("v%0d valid", i), 32'(out_valid), 32'(vt[i].e_vld));
      chk($sformatf("v%0d flags", i), 32'({flag_z, flag_v, flag_n}),
          32'({vt[i].e_z, vt[i].e_v, vt[i].e_n}));
      chk($sformatf("v%0d redirect", i), 32'(redirect), 32'(vt[i].e_rdr));
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 1);
      if (vt[i].e_rdr)
        chk($sformatf("v%0d redirect_pc", i), 32'(redirect_pc), 32'(vt[i].e_rpc));
      if (vt[i].e_vld) begin
        chk($sformatf("v%0d result", i), 32'(out_result), 32'(vt[i].e_res));
        chk($sformatf("v%0d wr_en", i), 32'(out_wr_en), 32'(vt[i].e_we));
        chk($sformatf("v%0d mem_rd", i), 32'(out_mem_rd), 32'(vt[i].e_rd));
        chk($sformatf("v%0d mem_wr", i), 32'(out_mem_wr), 32'(vt[i].e_wr));
        chk($sformatf("v%0d out_op", i), 32'(out_op), 32'(vt[i].op));
        chk($sformatf("v%0d wr_reg", i), 32'(out_wr_reg), 32'(vt[i].wr));
        chk($sformatf("v%0d store_data", i), 32'(out_store_data), 32'(vt[i].sd));
      end
    end

    // Stall hold: LW result stays put while an ADD waits for three cycles.
    set_in(1, 4'h8, 3'd0, 16'h1234, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 4'h7);
    step();
    chk("lw mem_rd", 32'(out_mem_rd), 1);
    chk("lw result", 32'(out_result), 32'h1234);
    set_in(1, 4'h0, 3'd0, 16'h5555, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 4'h3);
    mem_stall = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall%0d in_ready", k), 32'(in_ready), 0);
      step();
      chk($sformatf("stall%0d valid", k), 32'(out_valid), 1);
      chk($sformatf("stall%0d mem_rd", k), 32'(out_mem_rd), 1);
      chk($sformatf("stall%0d result", k), 32'(out_result), 32'h1234);
    end
    mem_stall = 1'b0;
    #1;
    chk("unstall in_ready", 32'(in_ready), 1);
    step();
    chk("add after stall result", 32'(out_result), 32'h5555);
    chk("add after stall op", 32'(out_op), 0);
    chk("add after stall rd", 32'(out_mem_rd), 0);
    chk("add after stall we", 32'(out_wr_en), 1);

    // Redirect held across a stall, then the waiting instruction is squashed.
    set_in(1, 4'hC, 3'd7, 16'h0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0ABC, 4'h0);
    step();
    chk("br redirect", 32'(redirect), 1);
    set_in(1, 4'h0, 3'd0, 16'h6666, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 4'h3);
    mem_stall = 1'b1;
    step(); step();
    chk("stalled redirect", 32'(redirect), 1);
    chk("stalled redirect_pc", 32'(redirect_pc), 32'h0ABC);
    mem_stall = 1'b0;
    step();
    chk("post-stall squash valid", 32'(out_valid), 0);
    chk("post-stall squash redirect", 32'(redirect), 0);
    step();
    chk("after squash valid", 32'(out_valid), 1);
    chk("after squash result", 32'(out_result), 32'h6666);

    // Async reset while a redirect is pending with Z set.
    set_in(1, 4'h2, 3'd0, 16'h0, 0, 1, 0, 1, 1, 1, 16'h0, 16'h0, 16'h0, 4'h1);
    step();
    set_in(1, 4'hC, 3'd1, 16'h0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0040, 4'h0);
    step();
    chk("pre-reset redirect", 32'(redirect), 1);
    chk("pre-reset z", 32'(flag_z), 1);
    in_valid = 1'b0;
    mem_stall = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async redir");
    mem_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post-reset in_ready", 32'(in_ready), 1);

    // Halt is sticky and blocks further accepts until reset.
    set_in(1, 4'h2, 3'd0, 16'h0, 0, 1, 0, 1, 1, 1, 16'h0, 16'h0, 16'h0, 4'h1);
    step();
    set_in(1, 4'hF, 3'd0, 16'h0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 4'h2);
    step();
    chk("hlt halt", 32'(halt), 1);
    chk("hlt in_ready", 32'(in_ready), 0);
    chk("hlt valid", 32'(out_valid), 1);
    chk("hlt wr_en", 32'(out_wr_en), 0);
    chk("hlt op", 32'(out_op), 32'hF);
    set_in(1, 4'h0, 3'd0, 16'h7777, 0, 0, 0, 0, 1, 0, 16'h0, 16'h0, 16'h0, 4'h3);
    step(); step();
    chk("halted valid", 32'(out_valid), 0);
    chk("halted halt", 32'(halt), 1);
    chk("halted in_ready", 32'(in_ready), 0);
    chk("halted z", 32'(flag_z), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async halt");
    chk("async halt in_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("restart valid", 32'(out_valid), 1);
    chk("restart result", 32'(out_result), 32'h7777);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
